// File: rtl/en_dff_chk_pkg.sv
// Shared state encoding and default widths for the enable-DFF response checker.
package en_dff_chk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int DEF_NUM_CYCLES = 10;
  localparam int DEF_CNT_W      = 8;
  localparam int DEF_ERR_W      = 8;

endpackage

// File: rtl/en_dff_checker_sat_counter.sv
// Saturating up-counter: holds at all-ones, clear wins over increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/en_dff_checker.sv
// Cycle-accurate monitor for an enable D flip-flop: tracks the expected q,
// counts mismatches over a fixed run length and reports pass/fail.
module en_dff_checker
  import en_dff_chk_pkg::*;
#(
  parameter int NUM_CYCLES = DEF_NUM_CYCLES,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int ERR_W      = DEF_ERR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             en,
  input  logic             d,
  input  logic             q,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             mismatch,
  output logic [ERR_W-1:0] err_count,
  output logic [CNT_W-1:0] first_err_cycle,
  output logic [CNT_W-1:0] cyc
);

  localparam logic [CNT_W-1:0] LAST_CYC = CNT_W'(NUM_CYCLES - 1);

  state_e             state_q;
  logic               model_valid_q;
  logic               exp_q;
  logic               busy_q;
  logic               done_q;
  logic               pass_q;
  logic               mismatch_q;
  logic [CNT_W-1:0]   first_err_q;
  logic [CNT_W-1:0]   cyc_q;
  logic [ERR_W-1:0]   err_count_w;

  logic err_hit;
  logic clr_results;
  logic model_upd;

  // The compare sees exp_q before this edge's model update.
  assign err_hit     = (state_q == RUN) && model_valid_q && (q != exp_q);
  assign clr_results = ((state_q == IDLE) || (state_q == DONE)) && start;
  assign model_upd   = ((state_q == ARM) || (state_q == RUN)) && en;

  sat_counter #(.W(ERR_W)) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr_results),
    .inc   (err_hit),
    .count (err_count_w)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      model_valid_q <= 1'b0;
      exp_q         <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      mismatch_q    <= 1'b0;
      first_err_q   <= '1;
      cyc_q         <= '0;
    end else begin
      mismatch_q <= err_hit;
      if (model_upd) begin
        exp_q         <= d;
        model_valid_q <= 1'b1;
      end
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q       <= ARM;
            busy_q        <= 1'b1;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            cyc_q         <= '0;
            first_err_q   <= '1;
            model_valid_q <= 1'b0;
          end
        end
        ARM: begin
          state_q <= RUN;
        end
        RUN: begin
          if (err_hit && (err_count_w == '0)) begin
            first_err_q <= cyc_q;
          end
          cyc_q <= cyc_q + 1'b1;
          if (cyc_q == LAST_CYC) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_count_w == '0) && !err_hit;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign mismatch        = mismatch_q;
  assign err_count       = err_count_w;
  assign first_err_cycle = first_err_q;
  assign cyc             = cyc_q;

endmodule

// File: tb/tb_en_dff_checker.sv
// Scoreboard bench for en_dff_checker: a behavioural enable-DFF feeds q, a
// bench-side reference predicts every output cycle by cycle.
module tb_en_dff_checker;
  import en_dff_chk_pkg::*;

  localparam int N  = 10;
  localparam int CW = 8;
  localparam int EW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic en = 1'b0;
  logic d = 1'b1;
  logic q = 1'b0;

  logic          busy, done, pass, mismatch;
  logic [EW-1:0] err_count;
  logic [CW-1:0] first_err_cycle, cyc;
  logic          busy2, done2, pass2, mismatch2;
  logic [1:0]    err_count2;
  logic [CW-1:0] first_err_cycle2, cyc2;

  always #5 clk = ~clk;

  en_dff_checker #(.NUM_CYCLES(N), .CNT_W(CW), .ERR_W(EW)) u_dut (
    .clk(clk), .rst(rst), .start(start), .en(en), .d(d), .q(q),
    .busy(busy), .done(done), .pass(pass), .mismatch(mismatch),
    .err_count(err_count), .first_err_cycle(first_err_cycle), .cyc(cyc)
  );

  en_dff_checker #(.NUM_CYCLES(N), .CNT_W(CW), .ERR_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start), .en(en), .d(d), .q(q),
    .busy(busy2), .done(done2), .pass(pass2), .mismatch(mismatch2),
    .err_count(err_count2), .first_err_cycle(first_err_cycle2), .cyc(cyc2)
  );

  // Behavioural enable DFF standing in for the device being monitored.
  logic dff_q;
  always @(posedge clk) if (en) dff_q <= d;

  typedef struct packed {
    logic          busy;
    logic          done;
    logic          pass;
    logic          mismatch;
    logic [EW-1:0] err;
    logic [CW-1:0] first;
    logic [CW-1:0] cyc;
    logic [1:0]    err2;
  } obs_t;

  obs_t sb_q[$];

  int checks = 0;
  int errors = 0;
  int mode = 0;      // 0 toggle, 1 toggle + q wrong from cyc 4, 2 toggle + q always wrong, 3 en low / q random
  int busy_cnt = 0;
  int mis_cnt = 0;

  state_e m_state = IDLE;
  logic   m_valid = 1'b0;
  logic   m_exp = 1'b0;
  logic   m_mis = 1'b0;
  int     m_cyc = 0;
  int     m_err = 0;
  int     m_first = 255;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic st, input logic r);
    obs_t e, o;
    logic inv, hit;
    start = st;
    rst   = r;
    inv = (mode == 2) || (mode == 1 && m_state == RUN && m_cyc >= 4);
    q = (mode == 3) ? 1'($urandom) : (dff_q ^ inv);
    m_mis = 1'b0;
    if (r) begin
      m_state = IDLE; m_valid = 1'b0; m_exp = 1'b0;
      m_cyc = 0; m_err = 0; m_first = 255;
    end else begin
      case (m_state)
        IDLE, DONE: if (st) begin
          m_state = ARM; m_cyc = 0; m_err = 0; m_first = 255; m_valid = 1'b0;
        end
        ARM: begin
          if (en) begin m_exp = d; m_valid = 1'b1; end
          m_state = RUN;
        end
        RUN: begin
          hit = m_valid && (q != m_exp);
          m_mis = hit;
          if (hit) begin
            if (m_err == 0) m_first = m_cyc;
            if (m_err < 255) m_err++;
          end
          if (en) begin m_exp = d; m_valid = 1'b1; end
          if (m_cyc == N - 1) m_state = DONE;
          m_cyc++;
        end
        default: m_state = IDLE;
      endcase
    end
    e.busy     = (m_state == ARM) || (m_state == RUN);
    e.done     = (m_state == DONE);
    e.pass     = (m_state == DONE) && (m_err == 0);
    e.mismatch = m_mis;
    e.err      = EW'(m_err);
    e.first    = CW'(m_first);
    e.cyc      = CW'(m_cyc);
    e.err2     = (m_err > 3) ? 2'd3 : 2'(m_err);
    sb_q.push_back(e);

    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    o = '{busy, done, pass, mismatch, err_count, first_err_cycle, cyc, err_count2};
    check_eq("cycle", 64'(o), 64'(e));
    if (busy) busy_cnt++;
    if (mismatch) mis_cnt++;

    start = 1'b0;
    rst   = 1'b0;
    if (mode == 3) begin
      en = 1'b0;
      d  = 1'($urandom);
    end else begin
      {en, d} = {d, ~en};
    end
  endtask

  task automatic run_to_done();
    for (int i = 0; i < 30 && !done; i++) step(1'b0, 1'b0);
    check_eq("done_timeout", 64'(done), 64'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_busy"}, 64'(busy), 64'd0);
    check_eq({tag, "_done"}, 64'(done), 64'd0);
    check_eq({tag, "_pass"}, 64'(pass), 64'd0);
    check_eq({tag, "_mismatch"}, 64'(mismatch), 64'd0);
    check_eq({tag, "_err"}, 64'(err_count), 64'd0);
    check_eq({tag, "_first"}, 64'(first_err_cycle), 64'hFF);
    check_eq({tag, "_cyc"}, 64'(cyc), 64'd0);
  endtask

  task automatic report(input string name);
    $display("run %s: done=%0b pass=%0b err=%0d err2=%0d first=%0d cyc=%0d busy_cycles=%0d pulses=%0d",
             name, done, pass, err_count, err_count2, first_err_cycle, cyc, busy_cnt, mis_cnt);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    check_reset_outputs("reset");

    // A: clean toggling run, start at cycle 2
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    busy_cnt = 0; mis_cnt = 0;
    step(1'b1, 1'b0);
    run_to_done();
    check_eq("A_busy_cycles", 64'(busy_cnt), 64'd11);
    check_eq("A_pass", 64'(pass), 64'd1);
    check_eq("A_err", 64'(err_count), 64'd0);
    check_eq("A_first", 64'(first_err_cycle), 64'hFF);
    check_eq("A_pulses", 64'(mis_cnt), 64'd0);
    check_eq("A_cyc", 64'(cyc), 64'd10);
    report("A");

    // B: q inverted from RUN cycle 4 onward
    mode = 1; busy_cnt = 0; mis_cnt = 0;
    step(1'b1, 1'b0);
    check_eq("B_done_drop", 64'(done), 64'd0);
    run_to_done();
    check_eq("B_first", 64'(first_err_cycle), 64'd4);
    check_eq("B_pass", 64'(pass), 64'd0);
    check_eq("B_err", 64'(err_count), 64'd6);
    check_eq("B_pulses", 64'(mis_cnt), 64'd6);
    report("B");

    // C: en held low, q random
    mode = 3; en = 1'b0; busy_cnt = 0; mis_cnt = 0;
    step(1'b1, 1'b0);
    run_to_done();
    check_eq("C_pass", 64'(pass), 64'd1);
    check_eq("C_err", 64'(err_count), 64'd0);
    check_eq("C_err2", 64'(err_count2), 64'd0);
    report("C");

    // D: q always wrong; narrow counter must saturate at 3
    mode = 2; en = 1'b0; d = 1'b1; busy_cnt = 0; mis_cnt = 0;
    step(1'b1, 1'b0);
    run_to_done();
    check_eq("D_err2_sat", 64'(err_count2), 64'd3);
    check_eq("D_err", 64'(err_count), 64'd10);
    check_eq("D_first", 64'(first_err_cycle), 64'd0);
    report("D");

    // E: reset at cyc 5, then clean rerun
    mode = 0; busy_cnt = 0; mis_cnt = 0;
    step(1'b1, 1'b0);
    check_eq("E_clear_err", 64'(err_count), 64'd0);
    check_eq("E_clear_first", 64'(first_err_cycle), 64'hFF);
    for (int i = 0; i < 20 && !(m_state == RUN && m_cyc == 5); i++) step(1'b0, 1'b0);
    check_eq("E_cyc_at_rst", 64'(cyc), 64'd5);
    step(1'b0, 1'b1);
    check_reset_outputs("E_rst");
    step(1'b1, 1'b0);
    run_to_done();
    check_eq("E_pass", 64'(pass), 64'd1);
    report("E");

    // F: start during RUN is ignored, start in DONE restarts
    busy_cnt = 0; mis_cnt = 0;
    step(1'b1, 1'b0);
    for (int i = 0; i < 20 && !(m_state == RUN && m_cyc == 3); i++) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    check_eq("F_ignored_cyc", 64'(cyc), 64'd4);
    check_eq("F_ignored_busy", 64'(busy), 64'd1);
    run_to_done();
    check_eq("F_cyc_done", 64'(cyc), 64'd10);
    step(1'b1, 1'b0);
    check_eq("F_restart_done", 64'(done), 64'd0);
    check_eq("F_restart_busy", 64'(busy), 64'd1);
    check_eq("F_restart_cyc", 64'(cyc), 64'd0);
    run_to_done();
    check_eq("F_pass", 64'(pass), 64'd1);
    report("F");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
